// File: rtl/pc_fetch_sequencer.sv
// Fetch PC sequencer: IDLE/RUN/PAUSE control, stall/redirect priority, epoch tag.
// Optional misaligned-redirect trap enabled by PC_MISALIGN_TRAP_EN.
module pc_fetch_sequencer #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int              PC_STEP      = 4,
   parameter int              STALL_W      = 6,
   parameter int              EPOCH_W      = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               go,
   input  logic [STALL_W-1:0] stall,
   input  logic               redirect_valid,
   input  logic [XLEN-1:0]    redirect_addr,
   input  logic               fetch_ready,
   output logic [XLEN-1:0]    pc,
   output logic               read_enable_cpu,
   output logic [EPOCH_W-1:0] epoch,
   output logic               redirect_flush
`ifdef PC_MISALIGN_TRAP_EN
   ,
   output logic               misalign_trap,
   output logic [XLEN-1:0]    misalign_addr
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   state_t             state_q;
   state_t             state_d;
   logic [XLEN-1:0]    pc_d;
   logic [XLEN-1:0]    target;
   logic [EPOCH_W-1:0] epoch_d;
   logic               accept;
   logic               inc;
   logic               redir_take;
   logic               redir_bad;

   // Stall bits above bit 0 belong to later stages.
   logic unused_bits;
`ifdef PC_MISALIGN_TRAP_EN
   assign unused_bits = ^stall[STALL_W-1:1];
`else
   assign unused_bits = ^{stall[STALL_W-1:1], redirect_addr[1:0]};
`endif

   // Redirect qualification; misaligned targets trap or are word-aligned.
   always_comb begin
      redir_take = 1'b0;
      redir_bad  = 1'b0;
      target     = redirect_addr;
`ifdef PC_MISALIGN_TRAP_EN
      redir_bad  = redirect_valid && (redirect_addr[1:0] != 2'b00);
      redir_take = redirect_valid && !redir_bad;
`else
      redir_take = redirect_valid;
      target     = {redirect_addr[XLEN-1:2], 2'b00};
`endif
   end

   // Request accepted by imem; any redirect suppresses the increment.
   assign accept = (state_q == RUN) && read_enable_cpu &&
                   fetch_ready && !stall[0];
   assign inc    = accept && !redirect_valid;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next state and next pc/epoch: redirect > stall > increment.
   always_comb begin
      state_d = state_q;
      pc_d    = pc;
      epoch_d = epoch;
      unique case (state_q)
         IDLE:    if (go)  state_d = RUN;
         RUN:     if (!go) state_d = PAUSE;
         PAUSE:   if (go)  state_d = RUN;
         default: state_d = IDLE;
      endcase
      if (redir_bad) state_d = PAUSE;
      unique case (1'b1)
         redir_take: begin
            pc_d    = target;
            epoch_d = epoch + EPOCH_W'(1);
         end
         inc:        pc_d = pc + XLEN'(PC_STEP);
         default:    ;
      endcase
   end

   // Registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc              <= RESET_VECTOR;
         epoch           <= '0;
         read_enable_cpu <= 1'b0;
         redirect_flush  <= 1'b0;
      end else begin
         pc              <= pc_d;
         epoch           <= epoch_d;
         read_enable_cpu <= (state_d == RUN);
         redirect_flush  <= redir_take;
      end
   end

`ifdef PC_MISALIGN_TRAP_EN
   // Trap pulse and captured bad target.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         misalign_trap <= 1'b0;
         misalign_addr <= '0;
      end else begin
         misalign_trap <= redir_bad;
         if (redir_bad) misalign_addr <= redirect_addr;
      end
   end
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer.
// Checks reset, stepping, stall, redirect, epoch wrap, pc wrap.
module tb_pc_fetch_sequencer;

   logic        clk;
   logic        reset;
   logic        go;
   logic [5:0]  stall;
   logic        redirect_valid;
   logic [31:0] redirect_addr;
   logic        fetch_ready;
   logic [31:0] pc;
   logic        read_enable_cpu;
   logic [1:0]  epoch;
   logic        redirect_flush;
`ifdef PC_MISALIGN_TRAP_EN
   logic        misalign_trap;
   logic [31:0] misalign_addr;
`endif

   int n_chk = 0;
   int n_err = 0;

   pc_fetch_sequencer dut (
      .clk             (clk),
      .reset           (reset),
      .go              (go),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_addr   (redirect_addr),
      .fetch_ready     (fetch_ready),
      .pc              (pc),
      .read_enable_cpu (read_enable_cpu),
      .epoch           (epoch),
      .redirect_flush  (redirect_flush)
`ifdef PC_MISALIGN_TRAP_EN
      ,
      .misalign_trap   (misalign_trap),
      .misalign_addr   (misalign_addr)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic redir(input logic [31:0] a);
      redirect_valid = 1'b1;
      redirect_addr  = a;
      step();
   endtask

   initial begin
      reset          = 1'b1;
      go             = 1'b0;
      stall          = '0;
      redirect_valid = 1'b0;
      redirect_addr  = '0;
      fetch_ready    = 1'b0;
      #3;
      chk("rst_pc", pc, 32'h0);
      chk("rst_ren", read_enable_cpu, 1'b0);
      chk("rst_ep", epoch, 2'd0);
      chk("rst_fl", redirect_flush, 1'b0);
`ifdef PC_MISALIGN_TRAP_EN
      chk("rst_trap", misalign_trap, 1'b0);
      chk("rst_maddr", misalign_addr, 32'h0);
`endif
      #4 reset = 1'b0;

      // idle with go low stays quiet
      step();
      chk("idle_ren", read_enable_cpu, 1'b0);

      // run: pc 0,4,8,C
      go = 1'b1;
      fetch_ready = 1'b1;
      step();
      chk("run_ren", read_enable_cpu, 1'b1);
      chk("run_pc0", pc, 32'h0);
      step();
      chk("run_pc4", pc, 32'h4);
      step();
      chk("run_pc8", pc, 32'h8);

      // fetch stall holds pc at 8
      stall = 6'b000001;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_pc", pc, 32'h8);
         chk("stall_ren", read_enable_cpu, 1'b1);
      end
      stall = '0;
      step();
      chk("resume_pc", pc, 32'hC);
      chk("resume_ep", epoch, 2'd0);

      // redirect overrides stall
      stall = 6'b000001;
      redir(32'h100);
      chk("rd_pc", pc, 32'h100);
      chk("rd_ep", epoch, 2'd1);
      chk("rd_fl", redirect_flush, 1'b1);
      redirect_valid = 1'b0;
      step();
      chk("rd_fl_end", redirect_flush, 1'b0);
      chk("rd_hold", pc, 32'h100);

      // bring epoch to 3, then 4 back-to-back
      redir(32'h200);
      redir(32'h300);
      chk("ep3", epoch, 2'd3);
      redir(32'h400);
      chk("b2b_ep0", epoch, 2'd0);
      chk("b2b_fl0", redirect_flush, 1'b1);
      redir(32'h500);
      chk("b2b_ep1", epoch, 2'd1);
      redir(32'h600);
      chk("b2b_ep2", epoch, 2'd2);
      chk("b2b_fl2", redirect_flush, 1'b1);
      redir(32'h704);
      chk("b2b_ep3", epoch, 2'd3);
      redirect_valid = 1'b0;
      step();
      chk("b2b_pc", pc, 32'h704);
      chk("b2b_fl_end", redirect_flush, 1'b0);

      // pc wraps past all-ones
      stall = '0;
      redir(32'hFFFF_FFFC);
      chk("wrap_pre", pc, 32'hFFFF_FFFC);
      chk("wrap_ep", epoch, 2'd0);
      redirect_valid = 1'b0;
      step();
      chk("wrap_pc", pc, 32'h0);

      // redirect beats a same-cycle accept
      redir(32'h40);
      chk("rda_pc", pc, 32'h40);
      chk("rda_ep", epoch, 2'd1);

      // misaligned redirect target
      redir(32'h102);
`ifdef PC_MISALIGN_TRAP_EN
      chk("mis_pc", pc, 32'h40);
      chk("mis_ep", epoch, 2'd1);
      chk("mis_trap", misalign_trap, 1'b1);
      chk("mis_addr", misalign_addr, 32'h102);
      chk("mis_fl", redirect_flush, 1'b0);
      chk("mis_ren", read_enable_cpu, 1'b0);
`else
      chk("mis_pc", pc, 32'h100);
      chk("mis_ep", epoch, 2'd2);
      chk("mis_fl", redirect_flush, 1'b1);
`endif
      redirect_valid = 1'b0;
      fetch_ready = 1'b0;
      step();
      chk("nordy_ren", read_enable_cpu, 1'b1);
`ifdef PC_MISALIGN_TRAP_EN
      chk("trap_end", misalign_trap, 1'b0);
      chk("nordy_pc", pc, 32'h40);
`else
      chk("nordy_pc", pc, 32'h100);
`endif

      // pause, redirect while paused, resume
      go = 1'b0;
      step();
      chk("pause_ren", read_enable_cpu, 1'b0);
      fetch_ready = 1'b1;
      step();
      chk("pause_hold_ren", read_enable_cpu, 1'b0);
      redir(32'h80);
      chk("pause_rd_pc", pc, 32'h80);
      chk("pause_rd_ren", read_enable_cpu, 1'b0);
`ifdef PC_MISALIGN_TRAP_EN
      chk("pause_rd_ep", epoch, 2'd2);
`else
      chk("pause_rd_ep", epoch, 2'd3);
`endif
      redirect_valid = 1'b0;
      go = 1'b1;
      step();
      chk("resume_ren", read_enable_cpu, 1'b1);
      chk("resume_pc80", pc, 32'h80);
      step();
      chk("resume_pc84", pc, 32'h84);

      // async reset mid-run, pending redirect dropped
      redirect_valid = 1'b1;
      redirect_addr  = 32'h500;
      #2 reset = 1'b1;
      #1;
      chk("arst_pc", pc, 32'h0);
      chk("arst_ren", read_enable_cpu, 1'b0);
      chk("arst_ep", epoch, 2'd0);
      chk("arst_fl", redirect_flush, 1'b0);
      step();
      chk("arst_hold_pc", pc, 32'h0);
      redirect_valid = 1'b0;
      reset = 1'b0;
      step();
      chk("post_rst_ren", read_enable_cpu, 1'b1);
      chk("post_rst_pc", pc, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end

endmodule
